// File: rtl/udp_pkg.sv
// Shared definitions for the Ethernet frame assembler and its CRC sub-module.
// Contents:
//   FRAME_WIDTH_DEF / MIN_BYTES_DEF : default frame buffer width (bits) and minimum length (bytes)
//   CRC_POLY / CRC_INIT / CRC_RESIDUE : reflected CRC-32 constants
//   drop_reason_t : encoding of the drop_reason output
//   state_t : assembler FSM states
//   crc32_byte() : one byte step of the reflected CRC-32
package udp_pkg;

  localparam int unsigned FRAME_WIDTH_DEF = 12000;
  localparam int unsigned MIN_BYTES_DEF   = 64;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    DROP_NONE = 2'b00,
    DROP_RUNT = 2'b01,
    DROP_OVF  = 2'b10,
    DROP_FCS  = 2'b11
  } drop_reason_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DROP    = 2'b10
  } state_t;

  // Advance a reflected CRC-32 register by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide running CRC-32 (reflected, no final inversion).
// Ports:
//   clk        : clock, rising edge
//   clear      : synchronous clear to CRC_INIT (priority over en)
//   en         : fold data into the running CRC this cycle
//   data       : input byte
//   crc_next_c : combinational CRC value including this cycle's byte
module eth_crc32
  import udp_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  logic [31:0] crc;

  assign crc_next_c = crc32_byte(crc, data);

  // Running CRC register
  always_ff @(posedge clk) begin
    if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next_c;
    end
  end

endmodule

// File: rtl/eth_frame_assembler.sv
// Assembles a byte stream into a frame buffer and publishes good frames.
// Optional FCS check is enabled by defining FRAME_ASM_FCS_CHECK_EN.
// Ports:
//   main_clk, main_rst : clock and synchronous active-high reset
//   rx_data/rx_valid/rx_last/rx_err : received byte stream, no backpressure
//   eth_frame   : last good frame, byte k at bits [8k+7:8k], unfilled bytes zero
//   frame_start : one-cycle pulse when eth_frame is updated
//   frame_len   : byte count of the frame held in eth_frame
//   frame_drop  : one-cycle pulse when a frame is discarded
//   drop_reason : 01 runt, 10 overflow/error, 11 FCS; held until the next drop
module eth_frame_assembler
  import udp_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = FRAME_WIDTH_DEF,
  parameter int unsigned MIN_BYTES   = MIN_BYTES_DEF
) (
  input  logic                   main_clk,
  input  logic                   main_rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_last,
  input  logic                   rx_err,
  output logic [FRAME_WIDTH-1:0] eth_frame,
  output logic                   frame_start,
  output logic [10:0]            frame_len,
  output logic                   frame_drop,
  output logic [1:0]             drop_reason
);

  localparam int unsigned MAX_BYTES = FRAME_WIDTH / 8;
  localparam int unsigned IDX_W     = $clog2(FRAME_WIDTH);

  state_t                 state;
  state_t                 state_nx;
  logic [10:0]            count;
  logic [FRAME_WIDTH-1:0] buffer;

  logic [10:0]            final_cnt_c;
  logic [IDX_W-1:0]       wr_idx_c;
  logic                   wr_c;
  logic                   good_c;
  logic                   runt_c;
  logic                   ovf_c;
  logic                   fcs_bad_c;
  logic                   end_c;
  logic                   fcs_ok_c;

  assign final_cnt_c = count + 11'd1;
  assign wr_idx_c    = IDX_W'({count, 3'b000});
  assign end_c       = good_c | runt_c | ovf_c | fcs_bad_c;

`ifdef FRAME_ASM_FCS_CHECK_EN
  logic [31:0] crc_next_c;

  // CRC covers every accepted byte including the FCS; cleared at each frame end
  eth_crc32 u_crc (
    .clk        (main_clk),
    .clear      (main_rst | end_c),
    .en         (rx_valid & ~rx_err & (state != ST_DROP)),
    .data       (rx_data),
    .crc_next_c (crc_next_c)
  );

  assign fcs_ok_c = (crc_next_c == CRC_RESIDUE);
`else
  assign fcs_ok_c = 1'b1;
`endif

  // State register
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-byte decisions; IDLE behaves as COLLECT with count 0
  always_comb begin
    state_nx  = state;
    wr_c      = 1'b0;
    good_c    = 1'b0;
    runt_c    = 1'b0;
    ovf_c     = 1'b0;
    fcs_bad_c = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (rx_err || (32'(count) >= MAX_BYTES)) begin
            // An error or a byte beyond the buffer ends in DROP, or at once if last
            if (rx_last) begin
              ovf_c    = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_DROP;
            end
          end else if (rx_last) begin
            state_nx = ST_IDLE;
            if (32'(final_cnt_c) < MIN_BYTES) begin
              runt_c = 1'b1;
            end else if (!fcs_ok_c) begin
              fcs_bad_c = 1'b1;
            end else begin
              good_c = 1'b1;
            end
          end else begin
            wr_c     = 1'b1;
            state_nx = ST_COLLECT;
          end
        end
        ST_DROP: begin
          if (rx_last) begin
            ovf_c    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Assembly buffer, published frame and status outputs
  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      count       <= 11'd0;
      buffer      <= '0;
      eth_frame   <= '0;
      frame_len   <= 11'd0;
      frame_start <= 1'b0;
      frame_drop  <= 1'b0;
      drop_reason <= DROP_NONE;
    end else begin
      frame_start <= good_c;
      frame_drop  <= runt_c | ovf_c | fcs_bad_c;
      if (wr_c) begin
        buffer[wr_idx_c +: 8] <= rx_data;
        count                 <= final_cnt_c;
      end
      if (end_c) begin
        buffer <= '0;
        count  <= 11'd0;
      end
      // Final byte is merged on the way out so it never waits a cycle in the buffer
      if (good_c) begin
        eth_frame <= buffer | (FRAME_WIDTH'(rx_data) << wr_idx_c);
        frame_len <= final_cnt_c;
      end
      if (runt_c) begin
        drop_reason <= DROP_RUNT;
      end else if (ovf_c) begin
        drop_reason <= DROP_OVF;
      end else if (fcs_bad_c) begin
        drop_reason <= DROP_FCS;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_assembler.sv
// Randomized self-checking bench for eth_frame_assembler with a queue-based
// reference model and directed literal checks of key frames.
// Define FRAME_ASM_FCS_CHECK_EN to exercise the FCS build.
module tb_eth_frame_assembler;

  localparam int unsigned FW   = 12000;
  localparam int unsigned MAXB = FW / 8;
  localparam int unsigned MINB = 64;

  typedef logic [7:0] byte_q_t[$];

  logic          main_clk = 1'b0;
  logic          main_rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_last;
  logic          rx_err;
  logic [FW-1:0] eth_frame;
  logic          frame_start;
  logic [10:0]   frame_len;
  logic          frame_drop;
  logic [1:0]    drop_reason;

  eth_frame_assembler dut (
    .main_clk    (main_clk),
    .main_rst    (main_rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_err      (rx_err),
    .eth_frame   (eth_frame),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .frame_drop  (frame_drop),
    .drop_reason (drop_reason)
  );

  always #5 main_clk = ~main_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]    cur[$];
  logic          dropping = 1'b0;
  logic          exp_start = 1'b0;
  logic          exp_drop = 1'b0;
  logic [1:0]    exp_reason = 2'd0;
  logic [10:0]   exp_len = 11'd0;
  logic [FW-1:0] exp_frame = '0;
  logic          chk_en = 1'b0;

  int cyc = 0;
  int start_cnt = 0;
  int last_start = 0;
  int prev_start = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Standard CRC-32 of a byte sequence (init all ones, final inversion)
  function automatic logic [31:0] crc32_std(input byte_q_t q, input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // A frame is FCS-bad when its trailing four bytes are not the CRC of the rest
  function automatic logic fcs_bad(input byte_q_t q);
`ifdef FRAME_ASM_FCS_CHECK_EN
    int n = q.size();
    logic [31:0] fcs = {q[n-1], q[n-2], q[n-3], q[n-4]};
    return fcs != crc32_std(q, n - 4);
`else
    return 1'b0 & q.size() > 0;
`endif
  endfunction

  // Expected outputs after the edge that consumed these inputs
  task automatic model_step(input logic [7:0] d, input logic v, input logic l,
                            input logic e, input logic r);
    exp_start = 1'b0;
    exp_drop  = 1'b0;
    if (r) begin
      cur.delete();
      dropping   = 1'b0;
      exp_frame  = '0;
      exp_len    = 11'd0;
      exp_reason = 2'd0;
    end else if (v) begin
      if (dropping) begin
        if (l) begin
          dropping = 1'b0; exp_drop = 1'b1; exp_reason = 2'd2;
        end
      end else if (e) begin
        cur.delete();
        if (l) begin exp_drop = 1'b1; exp_reason = 2'd2; end
        else dropping = 1'b1;
      end else begin
        cur.push_back(d);
        if (cur.size() > MAXB) begin
          cur.delete();
          if (l) begin exp_drop = 1'b1; exp_reason = 2'd2; end
          else dropping = 1'b1;
        end else if (l) begin
          if (cur.size() < MINB) begin
            exp_drop = 1'b1; exp_reason = 2'd1;
          end else if (fcs_bad(cur)) begin
            exp_drop = 1'b1; exp_reason = 2'd3;
          end else begin
            exp_start = 1'b1;
            exp_len   = 11'(cur.size());
            exp_frame = '0;
            for (int k = 0; k < cur.size(); k++) exp_frame[8*k +: 8] = cur[k];
          end
          cur.delete();
        end
      end
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge
  task automatic send(input logic [7:0] d, input logic v, input logic l,
                      input logic e, input logic r);
    rx_data = d; rx_valid = v; rx_last = l; rx_err = e; main_rst = r;
    @(posedge main_clk);
    #1;
    model_step(d, v, l, e, r);
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; main_rst = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t q, input logic gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 7) == 0)
        send(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
      send(q[i], 1'b1, (i == q.size() - 1), 1'b0, 1'b0);
    end
  endtask

  function automatic byte_q_t make_frame(input int n, input logic good_fcs);
    byte_q_t q;
    logic [31:0] c;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    if (good_fcs && n >= 8) begin
      c = crc32_std(q, n - 4);
      for (int b = 0; b < 4; b++) q[n-4+b] = c[8*b +: 8];
    end
    return q;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge main_clk) begin
    if (chk_en) begin
      cyc++;
      check("frame_start", 32'(frame_start), 32'(exp_start));
      check("frame_drop", 32'(frame_drop), 32'(exp_drop));
      check("frame_len", 32'(frame_len), 32'(exp_len));
      check("drop_reason", 32'(drop_reason), 32'(exp_reason));
      check("start_drop_exclusive", 32'(frame_start & frame_drop), 32'd0);
      total++;
      if (eth_frame !== exp_frame) begin
        bad++;
        $display("FAIL eth_frame: got low64 %h expected low64 %h (cycle %0d)",
                 eth_frame[63:0], exp_frame[63:0], cyc);
      end
      if (frame_start) begin
        start_cnt++;
        prev_start = last_start;
        last_start = cyc;
      end
    end
  end

  initial begin
    byte_q_t q;
    byte_q_t q2;
    int n;
    int sc;
    rx_data = 8'd0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; main_rst = 1'b1;
    send(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    send(8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge main_clk);
    check("reset_frame_len", 32'(frame_len), 32'd0);
    check("reset_drop_reason", 32'(drop_reason), 32'd0);
    check("reset_eth_frame_zero", 32'(eth_frame == '0), 32'd1);

`ifdef FRAME_ASM_FCS_CHECK_EN
    q = make_frame(64, 1'b1);
    send_frame(q, 1'b0);
    @(negedge main_clk);
    check("fcs_good_start", 32'(frame_start), 32'd1);
    check("fcs_good_len", 32'(frame_len), 32'd64);
    q[63] = q[63] ^ 8'h01;
    send_frame(q, 1'b0);
    @(negedge main_clk);
    check("fcs_bad_drop", 32'(frame_drop), 32'd1);
    check("fcs_bad_reason", 32'(drop_reason), 32'd3);
    check("fcs_bad_no_start", 32'(frame_start), 32'd0);
`else
    // 64-byte frame 0x00..0x3F
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(8'(i));
    send_frame(q, 1'b0);
    @(negedge main_clk);
    check("f64_start", 32'(frame_start), 32'd1);
    check("f64_len", 32'(frame_len), 32'd64);
    check("f64_byte0", 32'(eth_frame[7:0]), 32'h00);
    check("f64_byte63", 32'(eth_frame[511:504]), 32'h3F);
    check("f64_upper_zero", 32'(eth_frame[FW-1:512] == '0), 32'd1);

    // Runt leaves eth_frame untouched
    send_frame(make_frame(60, 1'b0), 1'b0);
    @(negedge main_clk);
    check("runt_drop", 32'(frame_drop), 32'd1);
    check("runt_reason", 32'(drop_reason), 32'd1);
    check("runt_no_start", 32'(frame_start), 32'd0);
    check("runt_frame_kept", 32'(eth_frame[511:504]), 32'h3F);

    // Overflow: 1501 bytes without last, then the last byte
    send_frame(make_frame(1502, 1'b0), 1'b0);
    @(negedge main_clk);
    check("ovf_drop", 32'(frame_drop), 32'd1);
    check("ovf_reason", 32'(drop_reason), 32'd2);
    q = make_frame(1500, 1'b0);
    send_frame(q, 1'b0);
    @(negedge main_clk);
    check("max_start", 32'(frame_start), 32'd1);
    check("max_len", 32'(frame_len), 32'd1500);
    check("max_last_byte", 32'(eth_frame[FW-1:FW-8]), 32'(q[1499]));

    // Back-to-back 64-byte frames
    q  = make_frame(64, 1'b0);
    q2 = make_frame(64, 1'b0);
    send_frame(q, 1'b0);
    send_frame(q2, 1'b0);
    @(negedge main_clk);
    check("b2b_spacing", 32'(last_start - prev_start), 32'd64);
    check("b2b_second_byte0", 32'(eth_frame[7:0]), 32'(q2[0]));

    // Reset mid-frame, then a clean frame
    sc = start_cnt;
    for (int i = 0; i < 30; i++) send(8'(i + 100), 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
    q = make_frame(64, 1'b0);
    send_frame(q, 1'b0);
    @(negedge main_clk);
    check("rst_single_pulse", 32'(start_cnt - sc), 32'd1);
    check("rst_second_start", 32'(frame_start), 32'd1);
    check("rst_second_byte0", 32'(eth_frame[7:0]), 32'(q[0]));
`endif

    // Randomized traffic with gaps, errors and occasional resets
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0:       n = $urandom_range(1, 63);
        1:       n = $urandom_range(1498, 1502);
        default: n = $urandom_range(60, 130);
      endcase
      q = make_frame(n, 1'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0)
          send(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
        send(q[i], 1'b1, (i == n - 1), ($urandom_range(0, 299) == 0),
             ($urandom_range(0, 499) == 0));
      end
      for (int g = $urandom_range(0, 3); g > 0; g--)
        send(8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge main_clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
